// File: rtl/matrix_pkg.sv
// Shared types for the 6x6 LED-matrix scan interface: geometry, frame layout
// and capture FSM states (also used by the display scanner).
package matrix_pkg;

    localparam int unsigned MATRIX_ROWS = 6;
    localparam int unsigned MATRIX_COLS = 6;

    // frame[r] holds the column pattern of row r
    typedef logic [MATRIX_ROWS-1:0][MATRIX_COLS-1:0] frame_t;

    typedef enum logic [0:0] {
        CAP_IDLE    = 1'b0,
        CAP_ACQUIRE = 1'b1
    } cap_state_e;

endpackage

// File: rtl/scan_onehot_decode.sv
// Combinational row-strobe decoder: index of the set bit, exactly-one flag,
// and more-than-one flag.
module scan_onehot_decode #(
    parameter  int unsigned N     = 6,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     row_i,
    output logic [IDX_W-1:0] idx_c_o,
    output logic             valid_c_o,
    output logic             multi_c_o
);

    logic [1:0] hits;

    // Population count saturating at two is enough to tell zero/one/many
    always_comb begin
        idx_c_o = '0;
        hits    = 2'd0;
        for (int i = 0; i < int'(N); i++) begin
            if (row_i[i]) begin
                idx_c_o = IDX_W'(i);
                if (hits != 2'd2) begin
                    hits = hits + 2'd1;
                end
            end
        end
        valid_c_o = (hits == 2'd1);
        multi_c_o = (hits == 2'd2);
    end

endmodule

// File: rtl/matrix_scan_capture.sv
// Rebuilds complete frames from the LED-matrix row/column scan and flags
// protocol errors and stalls. Define SCAN_DEGLITCH_EN to require inputs to
// settle for SETTLE cycles before they are recognised.
module matrix_scan_capture
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS    = MATRIX_ROWS,
    parameter int unsigned COLS    = MATRIX_COLS,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned SETTLE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ROWS-1:0]      row_in,
    input  logic [COLS-1:0]      col_in,
    output logic [ROWS*COLS-1:0] frame_out,
    output logic                 frame_valid,
    output logic [7:0]           frame_count,
    output logic [2:0]           row_idx,
    output logic                 onehot_err,
    output logic                 seq_err,
    output logic                 scan_stall
);

    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT);
    localparam int unsigned FRM_W = ROWS * COLS;

    if (TIMEOUT < 4 || SETTLE < 1) begin : g_bad_params
        $error("matrix_scan_capture: TIMEOUT must be >= 4 and SETTLE >= 1");
    end

    logic [ROWS-1:0]  row_q, prev_q;
    logic [COLS-1:0]  col_q;
    logic [ROWS-1:0]  eff_row;
    logic [COLS-1:0]  eff_col;
    logic [FRM_W-1:0] shadow_q, shadow_d, frame_q, frame_d;
    logic [ROWS-1:0]  seen_q, seen_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             fv_q, fv_d, oh_q, oh_d, seq_q, seq_d, stall_q, stall_d;
    cap_state_e       state_q, state_d;
    logic             row_evt;
    logic [IDX_W-1:0] dec_idx;
    logic             dec_valid, dec_multi;

`ifdef SCAN_DEGLITCH_EN
    localparam int unsigned STAB_W = $clog2(SETTLE + 1);

    logic [ROWS-1:0]   samp_row_q, sett_row_q;
    logic [COLS-1:0]   samp_col_q, sett_col_q;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              same, settled;

    // stab_q counts extra cycles the sample has repeated; until the pair has
    // held SETTLE cycles the last settled value stands in for it
    always_comb begin
        same    = (row_q == samp_row_q) && (col_q == samp_col_q);
        settled = (SETTLE <= 1) || (same && (32'(stab_q) + 32'd2 >= SETTLE));
        stab_d  = '0;
        if (same) begin
            stab_d = (32'(stab_q) < SETTLE) ? stab_q + STAB_W'(1) : stab_q;
        end
        eff_row = settled ? row_q : sett_row_q;
        eff_col = settled ? col_q : sett_col_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            samp_row_q <= '0;
            samp_col_q <= '0;
            sett_row_q <= '0;
            sett_col_q <= '0;
            stab_q     <= '0;
        end else begin
            samp_row_q <= row_q;
            samp_col_q <= col_q;
            sett_row_q <= eff_row;
            sett_col_q <= eff_col;
            stab_q     <= stab_d;
        end
    end
`else
    always_comb begin
        eff_row = row_q;
        eff_col = col_q;
    end
`endif

    scan_onehot_decode #(
        .N (ROWS)
    ) u_decode (
        .row_i     (eff_row),
        .idx_c_o   (dec_idx),
        .valid_c_o (dec_valid),
        .multi_c_o (dec_multi)
    );

    // Capture FSM, shadow buffer, frame counter and stall timer
    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        fv_d     = 1'b0;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oh_d     = 1'b0;
        seq_d    = 1'b0;
        stall_d  = stall_q;
        tmr_d    = tmr_q;
        row_evt  = (eff_row != prev_q);

        if (row_evt) begin
            tmr_d   = '0;
            stall_d = 1'b0;
            if (dec_multi) begin
                oh_d    = 1'b1;
                seen_d  = '0;
                state_d = CAP_IDLE;
            end else if (dec_valid) begin
                shadow_d[32'(dec_idx) * COLS +: COLS] = eff_col;
                idx_d           = 3'(dec_idx);
                seen_d[dec_idx] = 1'b1;
                case (state_q)
                    CAP_IDLE: begin
                        if (dec_idx == '0) begin
                            seen_d  = ROWS'(1);
                            state_d = CAP_ACQUIRE;
                        end
                    end
                    CAP_ACQUIRE: begin
                        if (32'(dec_idx) == 32'(idx_q) + 32'd1) begin
                            state_d = CAP_ACQUIRE;
                        end else if (dec_idx == '0) begin
                            // Publish the previous frame before row 0 is overwritten
                            seen_d = ROWS'(1);
                            if (&seen_q) begin
                                frame_d = shadow_q;
                                fv_d    = 1'b1;
                                cnt_d   = cnt_q + 8'd1;
                            end else begin
                                seq_d = 1'b1;
                            end
                        end else begin
                            seq_d   = 1'b1;
                            seen_d  = '0;
                            state_d = CAP_IDLE;
                        end
                    end
                    default: state_d = CAP_IDLE;
                endcase
            end
        end else if (32'(tmr_q) == TIMEOUT - 32'd1) begin
            stall_d = 1'b1;
            seen_d  = '0;
            state_d = CAP_IDLE;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            row_q    <= '0;
            col_q    <= '0;
            prev_q   <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            seen_q   <= '0;
            tmr_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            fv_q     <= 1'b0;
            oh_q     <= 1'b0;
            seq_q    <= 1'b0;
            stall_q  <= 1'b0;
            state_q  <= CAP_IDLE;
        end else begin
            row_q    <= row_in;
            col_q    <= col_in;
            prev_q   <= eff_row;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            seen_q   <= seen_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            fv_q     <= fv_d;
            oh_q     <= oh_d;
            seq_q    <= seq_d;
            stall_q  <= stall_d;
            state_q  <= state_d;
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = fv_q;
    assign frame_count = cnt_q;
    assign row_idx     = idx_q;
    assign onehot_err  = oh_q;
    assign seq_err     = seq_q;
    assign scan_stall  = stall_q;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Scoreboard bench for matrix_scan_capture: directed scan sequences push the
// expected pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_matrix_scan_capture;
    import matrix_pkg::*;

    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned SETTLE  = 3;
    localparam int unsigned HOLD    = 5;
`ifdef SCAN_DEGLITCH_EN
    localparam int unsigned EXTRA     = SETTLE - 1;
    localparam logic [7:0]  FINAL_CNT = 8'd3;
`else
    localparam int unsigned EXTRA     = 0;
    localparam logic [7:0]  FINAL_CNT = 8'd2;
`endif

    localparam logic [2:0] K_FRAME = 3'b100;
    localparam logic [2:0] K_OH    = 3'b010;
    localparam logic [2:0] K_SEQ   = 3'b001;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  row_in, col_in;
    logic [35:0] frame_out;
    logic        frame_valid, onehot_err, seq_err, scan_stall;
    logic [7:0]  frame_count;
    logic [2:0]  row_idx;

    always #5 clk = ~clk;

    matrix_scan_capture #(
        .TIMEOUT (TIMEOUT),
        .SETTLE  (SETTLE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_in      (row_in),
        .col_in      (col_in),
        .frame_out   (frame_out),
        .frame_valid (frame_valid),
        .frame_count (frame_count),
        .row_idx     (row_idx),
        .onehot_err  (onehot_err),
        .seq_err     (seq_err),
        .scan_stall  (scan_stall)
    );

    typedef struct {
        logic [2:0] kind;
        frame_t     frame;
        logic [7:0] count;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic frame_t mk_frame(input logic [5:0] c0, input logic [5:0] c1,
                                        input logic [5:0] c2, input logic [5:0] c3,
                                        input logic [5:0] c4, input logic [5:0] c5);
        return {c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic push_frame(input frame_t f, input logic [7:0] n);
        exp_t e;
        e.kind  = K_FRAME;
        e.frame = f;
        e.count = n;
        sb_q.push_back(e);
    endtask

    task automatic push_err(input logic [2:0] k);
        exp_t e;
        e.kind  = k;
        e.frame = '0;
        e.count = '0;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [5:0] rv, input logic [5:0] cv, input int n);
        row_in = rv;
        col_in = cv;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic row(input int r, input logic [5:0] cv);
        logic [5:0] rv;
        rv = 6'd1 << r;
        drive(rv, cv, HOLD);
    endtask

    // Monitor: every pulse must match the next scoreboard entry
    always @(negedge clk) begin
        if (reset && (frame_valid || onehot_err || seq_err)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got fv=%0b oh=%0b seq=%0b, expected none",
                         frame_valid, onehot_err, seq_err);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind", 64'({frame_valid, onehot_err, seq_err}), 64'(mon_e.kind));
                if (mon_e.kind == K_FRAME) begin
                    check("frame_out", 64'(frame_out), 64'(mon_e.frame));
                    check("frame_count", 64'(frame_count), 64'(mon_e.count));
                end
            end
        end
    end

    initial begin
        reset  = 1'b0;
        row_in = '0;
        col_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_frame_out", 64'(frame_out), 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);
        check("rst_row_idx", 64'(row_idx), 64'd0);
        check("rst_onehot_err", 64'(onehot_err), 64'd0);
        check("rst_seq_err", 64'(seq_err), 64'd0);
        check("rst_scan_stall", 64'(scan_stall), 64'd0);
        reset = 1'b1;

        // Full diagonal frame, two blanking slots, then row 0 closes it
        row(0, 6'h01); row(1, 6'h02); row(2, 6'h04);
        row(3, 6'h08); row(4, 6'h10); row(5, 6'h20);
        check("row_idx_row5", 64'(row_idx), 64'd5);
        drive(6'h00, 6'h00, HOLD);
        drive(6'h00, 6'h00, HOLD);
        push_frame(mk_frame(6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20), 8'd1);
        drive(6'b000001, 6'h00, 2 + EXTRA);
        check("frame_valid_latency", 64'(frame_valid), 64'd1);
        drive(6'b000001, 6'h00, HOLD - 2 - EXTRA);

        // Multi-hot mid-frame aborts; capture resumes at the next row 0
        row(1, 6'h05); row(2, 6'h0A);
        push_err(K_OH);
        drive(6'b000011, 6'h3F, HOLD);
        row(3, 6'h11); row(4, 6'h22); row(5, 6'h33);
        row(0, 6'h3F); row(1, 6'h2A); row(2, 6'h15);
        row(3, 6'h00); row(4, 6'h01); row(5, 6'h20);
        push_frame(mk_frame(6'h3F, 6'h2A, 6'h15, 6'h00, 6'h01, 6'h20), 8'd2);
        row(0, 6'h11);

        // Out of order 0,1,3
        row(1, 6'h22);
        push_err(K_SEQ);
        row(3, 6'h33);
        row(0, 6'h11); row(1, 6'h22); row(2, 6'h33);
        row(3, 6'h0C); row(4, 6'h30); row(5, 6'h07);
        push_frame(mk_frame(6'h11, 6'h22, 6'h33, 6'h0C, 6'h30, 6'h07), 8'd3);
        row(0, 6'h3E);

        // Early row 0 with an incomplete frame restarts acquisition
        row(1, 6'h3D); row(2, 6'h3B);
        push_err(K_SEQ);
        row(0, 6'h3E);
        row(1, 6'h3D); row(2, 6'h3B); row(3, 6'h37); row(4, 6'h2F); row(5, 6'h1F);
        push_frame(mk_frame(6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F), 8'd4);
        row(0, 6'h00);

        // Stall: row 2 (out of order) held past the timeout
        push_err(K_SEQ);
        drive(6'b000100, 6'h2A, TIMEOUT + 1 + EXTRA);
        check("stall_before_timeout", 64'(scan_stall), 64'd0);
        drive(6'b000100, 6'h2A, 1);
        check("stall_at_timeout", 64'(scan_stall), 64'd1);
        drive(6'b000100, 6'h2A, 3);
        check("stall_held", 64'(scan_stall), 64'd1);
        drive(6'b000001, 6'h00, HOLD);
        check("stall_cleared", 64'(scan_stall), 64'd0);

        // Reset mid-frame discards the partial frame and counters
        row(1, 6'h15); row(2, 6'h2A);
        reset = 1'b0;
        drive(6'h00, 6'h00, 2);
        check("midrst_frame_count", 64'(frame_count), 64'd0);
        check("midrst_frame_out", 64'(frame_out), 64'd0);
        check("midrst_row_idx", 64'(row_idx), 64'd0);
        reset = 1'b1;
        row(0, 6'h21); row(1, 6'h12); row(2, 6'h0C);
        row(3, 6'h0C); row(4, 6'h12); row(5, 6'h21);
        push_frame(mk_frame(6'h21, 6'h12, 6'h0C, 6'h0C, 6'h12, 6'h21), 8'd1);
        row(0, 6'h09);

        // One-cycle glitch to row 4 inside row 2
        row(1, 6'h06);
        drive(6'b000100, 6'h18, 4);
`ifndef SCAN_DEGLITCH_EN
        push_err(K_SEQ);
`endif
        drive(6'b010000, 6'h18, 1);
        drive(6'b000100, 6'h18, HOLD);
        row(3, 6'h24); row(4, 6'h30); row(5, 6'h03);
`ifdef SCAN_DEGLITCH_EN
        push_frame(mk_frame(6'h09, 6'h06, 6'h18, 6'h24, 6'h30, 6'h03), 8'd2);
`endif
        row(0, 6'h3C);
        row(1, 6'h01); row(2, 6'h02); row(3, 6'h03); row(4, 6'h04); row(5, 6'h05);
        push_frame(mk_frame(6'h3C, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05), FINAL_CNT);
        row(0, 6'h00);
        drive(6'h00, 6'h00, HOLD);

        check("final_frame_count", 64'(frame_count), 64'(FINAL_CNT));
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
